// File: rtl/secuenciador_tr_pkg.sv
// Shared definitions for the R-type instruction sequencer: FSM encoding,
// the legal opcode and instruction field positions.
package secuenciador_tr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_t;

  localparam logic [5:0] R_TYPE_OPCODE = 6'b000000;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/secuenciador_tr.sv
// Sequencer that fetches R-type instructions from address 0 to pc_fin,
// hands each to the datapath and pulses the register-bank write enable.
module secuenciador_tr
  import secuenciador_tr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [5:0]  OPCODE_R = R_TYPE_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_fin,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instruccion,
  output logic              br_we,
  input  logic              tr_zf,
  output logic              zf,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   instr_count
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_last;
  logic              illegal;

  assign illegal   = (opcode_of(instruccion) != OPCODE_R);
  assign imem_addr = pc;
  assign busy      = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_next = state;
    imem_rd    = 1'b0;
    br_we      = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        imem_rd    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT:   state_next = ST_DECODE;
      ST_DECODE: state_next = illegal ? ST_DONE : ST_EXEC;
      ST_EXEC:   state_next = ST_WB;
      ST_WB: begin
        br_we      = (rd_of(instruccion) != 5'd0);
        // Compare before incrementing so pc_fin at the top address never wraps
        state_next = (pc == pc_last) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Program counter, instruction latch, flags and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      pc_last     <= '0;
      instruccion <= '0;
      zf          <= 1'b0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc          <= '0;
            pc_last     <= pc_fin;
            instr_count <= '0;
            error       <= 1'b0;
            zf          <= 1'b0;
          end
        end
        ST_WAIT:   instruccion <= imem_data;
        ST_DECODE: if (illegal) error <= 1'b1;
        ST_EXEC:   zf <= tr_zf;
        ST_WB: begin
          instr_count <= instr_count + (ADDR_W+1)'(1);
          if (pc != pc_last) pc <= pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_tr.sv
// Directed bench for secuenciador_tr with a behavioural instruction memory.
module tb_secuenciador_tr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  pc_fin;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic [31:0] instruccion;
  logic        br_we;
  logic        tr_zf;
  logic        zf;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  int we_cyc[$];
  int addr_q[$];
  int done_cyc;
  int overlap;

  secuenciador_tr #(.ADDR_W(8), .OPCODE_R(6'b000000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_fin(pc_fin),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .instruccion(instruccion), .br_we(br_we), .tr_zf(tr_zf), .zf(zf),
    .busy(busy), .done(done), .error(error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data valid the cycle after the read strobe
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  task automatic fill_default();
    for (int i = 0; i < 256; i++) mem[i] = 32'h012A4020;
  endtask

  // Pulse start and record per-cycle activity; cycle 1 is the first cycle after start is sampled
  task automatic run_prog(input logic [7:0] fin, input int restart_cyc, input logic [7:0] alt_fin);
    we_cyc.delete();
    addr_q.delete();
    done_cyc = -1;
    overlap  = 0;
    @(negedge clk);
    pc_fin = fin;
    start  = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == restart_cyc) begin
        start  = 1'b1;
        pc_fin = alt_fin;
      end else begin
        start = 1'b0;
      end
      if (imem_rd) addr_q.push_back(int'(imem_addr));
      if (br_we) we_cyc.push_back(k);
      if (br_we && imem_rd) overlap++;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pc_fin = '0; tr_zf = 1'b0;
    fill_default();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, br_we, imem_rd, error, zf} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {busy, done, br_we, imem_rd, error, zf});
    end
    n_checks++;
    if (imem_addr !== 8'd0 || instr_count !== 9'd0 || instruccion !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs: got addr=%0d cnt=%0d instr=%h expected 0/0/0", imem_addr, instr_count, instruccion);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    fill_default();
    tr_zf = 1'b0;
    run_prog(8'd0, 0, 8'd0);
    n_checks++;
    if (we_cyc.size() != 1 || we_cyc[0] != 5) begin
      n_fail++; $display("FAIL single_we: got %p expected '{5}", we_cyc);
    end
    n_checks++;
    if (done_cyc != 6) begin
      n_fail++; $display("FAIL single_done: got %0d expected 6", done_cyc);
    end
    n_checks++;
    if (instr_count !== 9'd1 || error !== 1'b0 || zf !== 1'b0) begin
      n_fail++; $display("FAIL single_state: got cnt=%0d err=%b zf=%b expected 1/0/0", instr_count, error, zf);
    end
    n_checks++;
    if (instruccion !== 32'h012A4020) begin
      n_fail++; $display("FAIL single_instr: got %h expected 012a4020", instruccion);
    end
  endtask

  task automatic test_four();
    fill_default();
    mem[0] = 32'h012A4020;
    mem[1] = 32'h012A4022;
    mem[2] = 32'h014B6024;
    mem[3] = 32'h016C6825;
    run_prog(8'd3, 0, 8'd0);
    n_checks++;
    if (we_cyc.size() != 4 || we_cyc[0] != 5 || we_cyc[1] != 10 || we_cyc[2] != 15 || we_cyc[3] != 20) begin
      n_fail++; $display("FAIL four_we: got %p expected '{5,10,15,20}", we_cyc);
    end
    n_checks++;
    if (done_cyc != 21) begin
      n_fail++; $display("FAIL four_done: got %0d expected 21", done_cyc);
    end
    n_checks++;
    if (addr_q.size() != 4 || addr_q[0] != 0 || addr_q[1] != 1 || addr_q[2] != 2 || addr_q[3] != 3) begin
      n_fail++; $display("FAIL four_addr: got %p expected '{0,1,2,3}", addr_q);
    end
    n_checks++;
    if (instr_count !== 9'd4 || instruccion !== 32'h016C6825 || overlap != 0) begin
      n_fail++; $display("FAIL four_state: got cnt=%0d instr=%h ovl=%0d expected 4/016c6825/0", instr_count, instruccion, overlap);
    end
  endtask

  task automatic test_illegal();
    fill_default();
    mem[1] = 32'h8D280000;
    run_prog(8'd3, 0, 8'd0);
    n_checks++;
    if (we_cyc.size() != 1 || we_cyc[0] != 5) begin
      n_fail++; $display("FAIL illegal_we: got %p expected '{5}", we_cyc);
    end
    n_checks++;
    if (done_cyc != 9) begin
      n_fail++; $display("FAIL illegal_done: got %0d expected 9", done_cyc);
    end
    n_checks++;
    if (addr_q.size() != 2 || addr_q[0] != 0 || addr_q[1] != 1) begin
      n_fail++; $display("FAIL illegal_addr: got %p expected '{0,1}", addr_q);
    end
    n_checks++;
    if (error !== 1'b1 || instr_count !== 9'd1) begin
      n_fail++; $display("FAIL illegal_state: got err=%b cnt=%0d expected 1/1", error, instr_count);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_sticky: got err=%b busy=%b expected 1/0", error, busy);
    end
  endtask

  task automatic test_rd_zero_zf();
    fill_default();
    mem[0] = 32'h01290020;
    tr_zf  = 1'b0;
    run_prog(8'd0, 0, 8'd0);
    n_checks++;
    if (we_cyc.size() != 0 || instr_count !== 9'd1 || done_cyc != 6) begin
      n_fail++; $display("FAIL rd0_run: got we=%p cnt=%0d done=%0d expected '{}/1/6", we_cyc, instr_count, done_cyc);
    end
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++; $display("FAIL rd0_error_cleared: got %b expected 0", error);
    end
    mem[0] = 32'h01295022;
    tr_zf  = 1'b1;
    run_prog(8'd0, 0, 8'd0);
    tr_zf = 1'b0;
    n_checks++;
    if (zf !== 1'b1 || we_cyc.size() != 1) begin
      n_fail++; $display("FAIL sub_zf: got zf=%b we=%p expected 1/'{5}", zf, we_cyc);
    end
  endtask

  task automatic test_reset_mid_run();
    bit bad = 0;
    fill_default();
    @(negedge clk);
    pc_fin = 8'd3;
    start  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, br_we, imem_rd, error, zf} !== 6'b0 || imem_addr !== 8'd0 ||
        instr_count !== 9'd0 || instruccion !== 32'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got flags=%b addr=%0d cnt=%0d instr=%h expected all 0",
                         {busy, done, br_we, imem_rd, error, zf}, imem_addr, instr_count, instruccion);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || br_we || busy) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL midreset_quiet: got activity=1 expected 0");
    end
    rst_n = 1'b1;
    run_prog(8'd3, 0, 8'd0);
    n_checks++;
    if (done_cyc != 21 || addr_q.size() != 4 || addr_q[0] != 0 || addr_q[3] != 3) begin
      n_fail++; $display("FAIL midreset_rerun: got done=%0d addr=%p expected 21/'{0,1,2,3}", done_cyc, addr_q);
    end
  endtask

  task automatic test_start_while_busy();
    fill_default();
    run_prog(8'd1, 3, 8'd3);
    n_checks++;
    if (done_cyc != 11 || instr_count !== 9'd2 || we_cyc.size() != 2 || addr_q.size() != 2) begin
      n_fail++; $display("FAIL busy_start: got done=%0d cnt=%0d we=%p addr=%p expected 11/2/'{5,10}/'{0,1}",
                         done_cyc, instr_count, we_cyc, addr_q);
    end
    run_prog(8'd1, 11, 8'd3);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done_cyc != 11) begin
      n_fail++; $display("FAIL done_start: got busy=%b done=%0d expected 0/11", busy, done_cyc);
    end
  endtask

  task automatic test_max_pc_fin();
    bit seq_ok = 1;
    fill_default();
    run_prog(8'd255, 0, 8'd0);
    n_checks++;
    if (done_cyc != 1281 || instr_count !== 9'd256) begin
      n_fail++; $display("FAIL max_run: got done=%0d cnt=%0d expected 1281/256", done_cyc, instr_count);
    end
    for (int i = 0; i < 256; i++) if (addr_q.size() != 256 || addr_q[i] != i) seq_ok = 0;
    n_checks++;
    if (!seq_ok || we_cyc.size() != 256) begin
      n_fail++; $display("FAIL max_addr_seq: got naddr=%0d nwe=%0d inorder=%0d expected 256/256/1",
                         addr_q.size(), we_cyc.size(), seq_ok);
    end
    n_checks++;
    if (imem_addr !== 8'd255) begin
      n_fail++; $display("FAIL max_no_wrap: got addr=%0d expected 255", imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_illegal();
    test_rd_zero_zf();
    test_reset_mid_run();
    test_start_while_busy();
    test_max_pc_fin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/secuenciador_tr.md
SECUENCIADOR_TR -- requirements
Module: secuenciador_tr

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter OPCODE_R, default 6'b000000, only legal opcode (R-type).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to run program from address 0.
REQ-006 pc_fin  input  ADDR_W  index of last instruction (inclusive), sampled at start.
REQ-007 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-008 imem_rd  output  1  instruction-memory read strobe.
REQ-009 imem_data  input  32  read data, valid the cycle after imem_rd.
REQ-010 instruccion  output  32  latched instruction driven to the R-type datapath.
REQ-011 br_we  output  1  register-bank write enable.
REQ-012 tr_zf  input  1  zero flag from datapath.
REQ-013 zf  output  1  zero flag captured for last executed instruction.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 error  output  1  sticky illegal-opcode flag.
REQ-017 instr_count  output  ADDR_W+1  number of instructions completed (written back or skipped) in current run.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT, DECODE, EXEC, WB, DONE.
REQ-019 IDLE: start=1 -> FETCH; pc<=0, pc_fin latched, instr_count<=0, error<=0, zf<=0.
REQ-020 FETCH: imem_rd=1, imem_addr=pc; -> WAIT.
REQ-021 WAIT: instruccion<=imem_data; -> DECODE.
REQ-022 DECODE: instruccion[31:26]!=OPCODE_R -> error<=1, -> DONE; else -> EXEC.
REQ-023 EXEC: zf<=tr_zf at end of cycle; -> WB.
REQ-024 WB: br_we=1 for exactly this cycle unless rd field instruccion[15:11]==0 (br_we stays 0); instr_count increments; pc==pc_fin -> DONE, else pc<=pc+1, -> FETCH.
REQ-025 DONE: done=1 one cycle; -> IDLE.
REQ-026 Latency: 5 cycles per legal instruction; run of N instructions: done asserted 5N+1 cycles after start sampled.
REQ-027 instruccion held stable from WAIT exit until next WAIT; imem_rd and br_we never both high.
REQ-028 start while busy=1 ignored; start in DONE cycle ignored.
REQ-029 pc_fin changes during run have no effect.
REQ-030 pc_fin=2^ADDR_W-1: run ends after last address; pc never wraps to 0 mid-run.
REQ-031 Illegal opcode: no br_we for that instruction, instr_count not incremented, error stays 1 until next accepted start.
REQ-032 imem_addr holds pc in all states; imem_rd=0 outside FETCH.

Reset
REQ-033 rst_n=0 asynchronously forces IDLE; pc, instruccion, zf, instr_count, error, busy, done, br_we, imem_rd to 0; imem_addr to 0.
REQ-034 Reset mid-run aborts without done pulse; no br_we after rst_n falls.
REQ-035 First start accepted on first rising edge with rst_n=1.

Structure
REQ-036 Shared package holds FSM state encoding, OPCODE_R, instruction field positions (opcode [31:26], rd [15:11]).
REQ-037 Single module; no sub-module required; pc/instr_count counters inline.

Verification
REQ-038 Reset then start, pc_fin=0, mem[0]=32'h012A4020 (add $8,$9,$10) -> one br_we pulse in cycle 5, done cycle 6, instr_count=1, error=0.
REQ-039 pc_fin=3, four legal R-type words -> four br_we pulses 5 cycles apart, done 21 cycles after start, imem_addr sequence 0,1,2,3.
REQ-040 mem[1]=32'h8D280000 (lw, opcode 6'h23), pc_fin=3 -> one br_we (addr 0), error=1, done pulse, instr_count=1, addresses 2,3 never read.
REQ-041 R-type with rd=0 (32'h01295020 with rd cleared -> 32'h01290020) -> no br_we, instr_count still 1; sub giving equal operands -> zf=1.
REQ-042 rst_n low during EXEC of second instruction -> immediate IDLE, all outputs 0, no done; new start re-runs from address 0.
REQ-043 start pulsed again while busy -> ignored, run completes with original pc_fin.
